// File: rtl/wb_unaligned_split.sv
// Wishbone request splitter: byte-addressed 16-bit master to word-addressed
// memory map. Byte and odd-address word accesses become lane-selected
// aligned word cycles. An odd word access becomes two byte cycles with a
// one-cycle strobe gap, and its halves are reassembled into dat_o.
module wb_unaligned_split #(
  parameter int ADR_W = 20,
  parameter bit SEXT  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ADR_W-1:0] adr_i,
  input  logic [15:0]      dat_i,
  output logic [15:0]      dat_o,
  input  logic             we_i,
  input  logic             byte_i,
  input  logic             stb_i,
  output logic             ack_o,
  output logic [ADR_W-2:0] m_adr_o,
  output logic [15:0]      m_dat_o,
  input  logic [15:0]      m_dat_i,
  output logic [1:0]       m_sel_o,
  output logic             m_we_o,
  output logic             m_stb_o,
  input  logic             m_ack_i
);

  localparam int WA = ADR_W - 1;

  typedef enum logic [2:0] {
    IDLE,
    BUS1,
    GAP,
    BUS2,
    ACK
  } state_t;

  state_t state_reg, state_next;

  // Latched master request
  logic [ADR_W-1:0] adr_reg, adr_next;
  logic [15:0]      dat_reg, dat_next;
  logic             we_reg, we_next;
  logic             byte_reg, byte_next;

  // Low byte of an odd word read, held until the second half returns so
  // dat_o only ever changes as a whole when a read completes.
  logic [7:0]       part_reg, part_next;

  // Registered outputs
  logic [15:0]      dato_reg, dato_next;
  logic             ack_reg, ack_next;
  logic [WA-1:0]    madr_reg, madr_next;
  logic [15:0]      mdat_reg, mdat_next;
  logic [1:0]       msel_reg, msel_next;
  logic             mwe_reg, mwe_next;
  logic             mstb_reg, mstb_next;

  // An odd-address word access needs two memory cycles.
  logic split;
  assign split = !byte_reg && adr_reg[0];

  // Byte read extension into the upper lane.
  function automatic logic [15:0] ext8(input logic [7:0] b);
    if (SEXT) begin
      ext8 = {{8{b[7]}}, b};
    end else begin
      ext8 = {8'h00, b};
    end
  endfunction

  // Next-state, first/second half mapping and read data assembly.
  always_comb begin
    state_next = state_reg;
    adr_next   = adr_reg;
    dat_next   = dat_reg;
    we_next    = we_reg;
    byte_next  = byte_reg;
    part_next  = part_reg;
    dato_next  = dato_reg;
    ack_next   = 1'b0;
    madr_next  = madr_reg;
    mdat_next  = mdat_reg;
    msel_next  = msel_reg;
    mwe_next   = mwe_reg;
    mstb_next  = mstb_reg;

    case (state_reg)
      IDLE: begin
        if (stb_i) begin
          adr_next   = adr_i;
          dat_next   = dat_i;
          we_next    = we_i;
          byte_next  = byte_i;
          state_next = BUS1;
          mstb_next  = 1'b1;
          mwe_next   = we_i;
          madr_next  = adr_i[ADR_W-1:1];
          if (!byte_i && !adr_i[0]) begin
            // Aligned word: single full-width cycle
            msel_next = 2'b11;
            mdat_next = dat_i;
          end else begin
            // Byte access or low byte of an odd word: one lane only,
            // data replicated so either lane carries it.
            msel_next = adr_i[0] ? 2'b10 : 2'b01;
            mdat_next = {dat_i[7:0], dat_i[7:0]};
          end
        end
      end

      BUS1: begin
        if (m_ack_i) begin
          mstb_next = 1'b0;
          if (!we_reg) begin
            if (byte_reg) begin
              dato_next = adr_reg[0] ? ext8(m_dat_i[15:8]) : ext8(m_dat_i[7:0]);
            end else if (!adr_reg[0]) begin
              dato_next = m_dat_i;
            end else begin
              part_next = m_dat_i[15:8];
            end
          end
          if (split) begin
            state_next = GAP;
          end else begin
            ack_next   = 1'b1;
            mwe_next   = 1'b0;
            state_next = ACK;
          end
        end
      end

      GAP: begin
        // High byte of the odd word lives in the even lane of the next word;
        // the word address wraps naturally at the top of the map.
        madr_next  = adr_reg[ADR_W-1:1] + WA'(1);
        msel_next  = 2'b01;
        mdat_next  = {dat_reg[15:8], dat_reg[15:8]};
        mstb_next  = 1'b1;
        state_next = BUS2;
      end

      BUS2: begin
        if (m_ack_i) begin
          if (!we_reg) begin
            dato_next = {m_dat_i[7:0], part_reg};
          end
          mstb_next  = 1'b0;
          mwe_next   = 1'b0;
          ack_next   = 1'b1;
          state_next = ACK;
        end
      end

      ACK: begin
        // stb_i is not looked at here; a held strobe is taken next cycle.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        mstb_next  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      adr_reg   <= '0;
      dat_reg   <= '0;
      we_reg    <= 1'b0;
      byte_reg  <= 1'b0;
      part_reg  <= '0;
      dato_reg  <= '0;
      ack_reg   <= 1'b0;
      madr_reg  <= '0;
      mdat_reg  <= '0;
      msel_reg  <= 2'b00;
      mwe_reg   <= 1'b0;
      mstb_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      adr_reg   <= adr_next;
      dat_reg   <= dat_next;
      we_reg    <= we_next;
      byte_reg  <= byte_next;
      part_reg  <= part_next;
      dato_reg  <= dato_next;
      ack_reg   <= ack_next;
      madr_reg  <= madr_next;
      mdat_reg  <= mdat_next;
      msel_reg  <= msel_next;
      mwe_reg   <= mwe_next;
      mstb_reg  <= mstb_next;
    end
  end

  assign dat_o   = dato_reg;
  assign ack_o   = ack_reg;
  assign m_adr_o = madr_reg;
  assign m_dat_o = mdat_reg;
  assign m_sel_o = msel_reg;
  assign m_we_o  = mwe_reg;
  assign m_stb_o = mstb_reg;

endmodule

// File: tb/tb_wb_unaligned_split.sv
// Scoreboard bench for wb_unaligned_split: directed vectors push expected
// memory cycles and master responses; a negedge monitor pops and compares.
// A second instance with zero extension shares all inputs.
module tb_wb_unaligned_split;

  localparam int ADR_W = 20;
  localparam int WA    = ADR_W - 1;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [ADR_W-1:0] adr_i;
  logic [15:0]      dat_i;
  logic             we_i, byte_i, stb_i;
  logic [15:0]      dat_o, dat_o_z;
  logic             ack_o, ack_o_z;
  logic [WA-1:0]    m_adr_o, m_adr_o_z;
  logic [15:0]      m_dat_o, m_dat_o_z;
  logic [1:0]       m_sel_o, m_sel_o_z;
  logic             m_we_o, m_we_o_z;
  logic             m_stb_o, m_stb_o_z;
  logic [15:0]      m_dat_i;
  logic             m_ack_i;

  always #5 clk = ~clk;

  wb_unaligned_split #(.ADR_W(ADR_W), .SEXT(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .byte_i(byte_i), .stb_i(stb_i), .ack_o(ack_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
    .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_ack_i(m_ack_i)
  );

  wb_unaligned_split #(.ADR_W(ADR_W), .SEXT(1'b0)) dut_z (
    .clk_i(clk), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o_z),
    .we_i(we_i), .byte_i(byte_i), .stb_i(stb_i), .ack_o(ack_o_z),
    .m_adr_o(m_adr_o_z), .m_dat_o(m_dat_o_z), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o_z),
    .m_we_o(m_we_o_z), .m_stb_o(m_stb_o_z), .m_ack_i(m_ack_i)
  );

  // Slave model: d1 for the first-half address, d2 otherwise; ack after
  // sl_wait cycles of strobe. stray injects acks outside any cycle.
  logic [WA-1:0] sl_a1;
  logic [15:0]   sl_d1, sl_d2;
  int            sl_wait;
  int            sl_cnt;
  logic          stray;

  assign m_dat_i = (m_adr_o == sl_a1) ? sl_d1 : sl_d2;
  assign m_ack_i = (m_stb_o && (sl_cnt >= sl_wait)) || stray;

  always @(posedge clk) begin
    if (!m_stb_o || m_ack_i) sl_cnt <= 0;
    else                     sl_cnt <= sl_cnt + 1;
  end

  typedef struct {
    logic [WA-1:0] adr;
    logic [1:0]    sel;
    logic [15:0]   dat;
    logic          we;
    logic          gap;
  } mem_exp_t;

  typedef struct {
    logic [15:0] ds;
    logic [15:0] dz;
  } ack_exp_t;

  typedef struct {
    logic [ADR_W-1:0] adr;
    logic [15:0]      wd;
    logic             we;
    logic             byt;
    int               wt;
    logic [15:0]      d1;
    logic [15:0]      d2;
    logic [WA-1:0]    a1;
    logic [1:0]       s1;
    logic [15:0]      md1;
    logic             split;
    logic [WA-1:0]    a2;
    logic [1:0]       s2;
    logic [15:0]      md2;
    logic [15:0]      es;
    logic [15:0]      ez;
  } vec_t;

  mem_exp_t mem_q[$];
  ack_exp_t ack_q[$];
  vec_t     vecs[10];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Monitor: memory-side completions, strobe gap and master acks.
  initial begin : monitor
    int       gap_phase;
    logic     prev_mack;
    mem_exp_t me;
    ack_exp_t ae;
    gap_phase = 0;
    prev_mack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        gap_phase = 0;
        prev_mack = 1'b0;
      end else begin
        if (gap_phase == 1) begin
          chk("gap_low", 32'(m_stb_o), 32'd0);
          gap_phase = 2;
        end else if (gap_phase == 2) begin
          chk("gap_high", 32'(m_stb_o), 32'd1);
          gap_phase = 0;
        end
        if (m_stb_o && m_ack_i) begin
          if (mem_q.size() == 0) begin
            bad("unexpected_mem_cycle");
          end else begin
            me = mem_q.pop_front();
            chk("m_adr", 32'(m_adr_o), 32'(me.adr));
            chk("m_sel", 32'(m_sel_o), 32'(me.sel));
            chk("m_dat", 32'(m_dat_o), 32'(me.dat));
            chk("m_we",  32'(m_we_o),  32'(me.we));
            chk("m_adr_z", 32'(m_adr_o_z), 32'(me.adr));
            chk("m_sel_z", 32'(m_sel_o_z), 32'(me.sel));
            chk("m_dat_z", 32'(m_dat_o_z), 32'(me.dat));
            chk("m_we_z",  32'(m_we_o_z),  32'(me.we));
            chk("m_stb_z", 32'(m_stb_o_z), 32'd1);
            if (me.gap) gap_phase = 1;
          end
        end
        if (ack_o) begin
          chk("ack_latency", 32'(prev_mack), 32'd1);
          if (ack_q.size() == 0) begin
            bad("unexpected_ack");
          end else begin
            ae = ack_q.pop_front();
            $display("ack: dat_o=%h dat_o_z=%h", dat_o, dat_o_z);
            chk("dat_o",   32'(dat_o),   32'(ae.ds));
            chk("dat_o_z", 32'(dat_o_z), 32'(ae.dz));
            chk("ack_z",   32'(ack_o_z), 32'd1);
          end
        end
        prev_mack = m_stb_o && m_ack_i;
      end
    end
  end

  task automatic issue(input vec_t v);
    adr_i   = v.adr;
    dat_i   = v.wd;
    we_i    = v.we;
    byte_i  = v.byt;
    stb_i   = 1'b1;
    sl_a1   = v.a1;
    sl_d1   = v.d1;
    sl_d2   = v.d2;
    sl_wait = v.wt;
    mem_q.push_back('{v.a1, v.s1, v.md1, v.we, v.split});
    if (v.split) mem_q.push_back('{v.a2, v.s2, v.md2, v.we, 1'b0});
    ack_q.push_back('{v.es, v.ez});
  endtask

  task automatic wait_ack();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ack_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) bad("ack_timeout");
  endtask

  // Issue one request (from IDLE or straight after ACK with stb_i held).
  task automatic run_vec(input vec_t v);
    @(posedge clk);
    #1;
    issue(v);
    @(negedge clk);
    chk("b2b_idle", 32'(m_stb_o), 32'd0);
    @(negedge clk);
    chk("b2b_start", 32'(m_stb_o), 32'd1);
    wait_ack();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ack"},   32'(ack_o),   32'd0);
    chk({tag, "_stb"},   32'(m_stb_o), 32'd0);
    chk({tag, "_we"},    32'(m_we_o),  32'd0);
    chk({tag, "_dat_o"}, 32'(dat_o),   32'd0);
    chk({tag, "_m_dat"}, 32'(m_dat_o), 32'd0);
    chk({tag, "_m_adr"}, 32'(m_adr_o), 32'd0);
    chk({tag, "_m_sel"}, 32'(m_sel_o), 32'd0);
  endtask

  initial begin : stim
    vec_t vr;
    bit   hit;
    //          adr       wd        we    byt   wt d1        d2        a1        s1     md1       sp    a2        s2     md2       es        ez
    vecs[0] = '{20'hC0004, 16'h5A5A, 1'b0, 1'b0, 0, 16'h0A0B, 16'h0000, 19'h60002, 2'b11, 16'h5A5A, 1'b0, 19'h00000, 2'b00, 16'h0000, 16'h0A0B, 16'h0A0B};
    vecs[1] = '{20'hC0040, 16'h00F0, 1'b0, 1'b1, 1, 16'h1283, 16'h0000, 19'h60020, 2'b01, 16'hF0F0, 1'b0, 19'h00000, 2'b00, 16'h0000, 16'hFF83, 16'h0083};
    vecs[2] = '{20'h0000D, 16'h1234, 1'b1, 1'b0, 0, 16'h0000, 16'h0000, 19'h00006, 2'b10, 16'h3434, 1'b1, 19'h00007, 2'b01, 16'h1212, 16'hFF83, 16'h0083};
    vecs[3] = '{20'hB8003, 16'h0000, 1'b0, 1'b0, 3, 16'h65AA, 16'h7403, 19'h5C001, 2'b10, 16'h0000, 1'b1, 19'h5C002, 2'b01, 16'h0000, 16'h0365, 16'h0365};
    vecs[4] = '{20'hFFFFF, 16'h9876, 1'b0, 1'b0, 0, 16'hC311, 16'h22F7, 19'h7FFFF, 2'b10, 16'h7676, 1'b1, 19'h00000, 2'b01, 16'h9898, 16'hF7C3, 16'hF7C3};
    vecs[5] = '{20'h00019, 16'h0062, 1'b1, 1'b1, 0, 16'h0000, 16'h0000, 19'h0000C, 2'b10, 16'h6262, 1'b0, 19'h00000, 2'b00, 16'h0000, 16'hF7C3, 16'hF7C3};
    vecs[6] = '{20'h00019, 16'h0000, 1'b0, 1'b1, 0, 16'h9A00, 16'h0000, 19'h0000C, 2'b10, 16'h0000, 1'b0, 19'h00000, 2'b00, 16'h0000, 16'hFF9A, 16'h009A};
    vecs[7] = '{20'h00100, 16'hABCD, 1'b1, 1'b0, 2, 16'h0000, 16'h0000, 19'h00080, 2'b11, 16'hABCD, 1'b0, 19'h00000, 2'b00, 16'h0000, 16'hFF9A, 16'h009A};
    vecs[8] = '{20'h00101, 16'h0011, 1'b0, 1'b1, 0, 16'h7F11, 16'h0000, 19'h00080, 2'b10, 16'h1111, 1'b0, 19'h00000, 2'b00, 16'h0000, 16'h007F, 16'h007F};
    vecs[9] = '{20'h00222, 16'h0000, 1'b0, 1'b1, 0, 16'h4455, 16'h0000, 19'h00111, 2'b01, 16'h0000, 1'b0, 19'h00000, 2'b00, 16'h0000, 16'h0055, 16'h0055};

    rst_i = 1'b1; stb_i = 1'b0; adr_i = '0; dat_i = '0; we_i = 1'b0; byte_i = 1'b0;
    sl_a1 = '0; sl_d1 = '0; sl_d2 = '0; sl_wait = 0; stray = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk);
    #1 rst_i = 1'b0;

    // Back-to-back sequence: stb_i stays high between requests.
    foreach (vecs[i]) run_vec(vecs[i]);
    @(posedge clk);
    #1 stb_i = 1'b0;

    // Reset while the second half of a split read is waiting on the slave.
    vr = vecs[3];
    vr.wt = 10;
    @(posedge clk);
    #1 issue(vr);
    hit = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (m_stb_o && (m_adr_o == 19'h5C002)) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) bad("bus2_timeout");
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    stb_i = 1'b0;
    mem_q.delete();
    ack_q.delete();
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk_reset_state("midrst");

    // Stray slave acks while idle must be ignored.
    @(posedge clk);
    #1 stray = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_ack", 32'(ack_o), 32'd0);
      chk("stray_stb", 32'(m_stb_o), 32'd0);
    end
    @(posedge clk);
    #1 stray = 1'b0;

    // Recovery after reset.
    run_vec(vecs[0]);
    @(posedge clk);
    #1 stb_i = 1'b0;
    repeat (3) @(negedge clk);
    if (mem_q.size() != 0 || ack_q.size() != 0) bad("scoreboard_leftover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
